par2ser_shifter: RTL and testbench
==================================

Name: par2ser_shifter

Overview:
Parallel-to-serial shifter that sits directly upstream of the serial pattern detector stage and drives its one-bit serial input.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the word one bit per clock, qualified by s_valid.
- Idles the serial line at 0 between words, so the detector never sees stale 1s.

Parameters:
WIDTH, 8, bits per parallel word; legal values are 2 or more.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
load_valid  input  1  load_data is valid this cycle.
load_data  input  WIDTH  parallel word to serialize.
load_ready  output  1  block can accept a word this cycle (combinational from state).
s_data  output  1  serial bit, registered; feeds the detector's s_data.
s_valid  output  1  s_data carries a payload bit this cycle, registered.
busy  output  1  a word is being shifted out (state is SHIFT).
done  output  1  one-cycle pulse, coincident with the last bit of each word.

Behaviour:
- Transfer rule: a word is accepted on a rising edge where load_valid and load_ready are both 1. load_data is sampled only at that edge.
- Reset (rst=1 at an edge):
  - state=IDLE, bit counter=0, shift register=0.
  - s_data=0, s_valid=0, done=0.
  - load_ready=0 while rst is high; load_ready=1 in the first cycle after rst deasserts.
- FSM with two states:
  - IDLE: load_ready=1, s_valid=0, s_data=0. On accept: load shift register, set counter=WIDTH-1, go to SHIFT.
  - SHIFT: s_valid=1 and s_data = current head bit. Each edge shifts toward the head and decrements the counter.
  - In the counter==0 cycle: done=1. The next edge returns to IDLE (or loads the held word, see Optional Feature).
- Latency: word accepted at edge k → bit 0 of the stream appears in cycle k+1. The last bit and done appear in cycle k+WIDTH. s_valid is high for exactly WIDTH consecutive cycles.
- Bit order:
  - MSB_FIRST=1: load_data[WIDTH-1], then down to load_data[0].
  - MSB_FIRST=0: load_data[0], then up to load_data[WIDTH-1].
- Without the optional feature:
  - load_ready=0 throughout SHIFT; load_valid is ignored there, and no word is duplicated or lost.
  - There is one IDLE cycle (s_valid=0, s_data=0) between consecutive words.
- Counter width is $clog2(WIDTH); the counter never wraps below 0.
- Reset mid-word: the word is discarded. s_valid=0 and s_data=0 from the cycle after the reset edge, done does not pulse, and shifting does not resume.
- s_data, s_valid and done are driven from flops; there is no combinational path from load_* to s_*.

Optional Feature:
Macro PAR2SER_PRELOAD_EN.
- Defined: adds a one-word holding register.
  - load_ready = !hold_full, in IDLE and in SHIFT.
  - A word accepted during SHIFT goes to the holding register.
  - In the counter==0 cycle, if hold_full, the next edge moves the held word into the shift register and stays in SHIFT. This gives a gapless stream with s_valid continuously 1.
  - If hold is empty in the counter==0 cycle and load_valid=1, the word is accepted and loaded straight into the shift register at that edge, also gapless.
  - Reset clears hold_full.
- Undefined: no holding register; behaviour is exactly as in Behaviour, with one idle cycle between words.

Test Plan:
1. Single word, WIDTH=8, MSB_FIRST=1: load 8'hA5 at edge 0 → s_data=1,0,1,0,0,1,0,1 in cycles 1–8 with s_valid=1; done=1 only in cycle 8; cycle 9 has s_valid=0, s_data=0, load_ready=1.
2. LSB-first, MSB_FIRST=0: load 8'hA5 → s_data=1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 read from bit 0 upward. Also load 8'h01 → 1 then seven 0s.
3. Back-to-back, macro undefined: load_valid held high with 8'hFF then 8'h00 → 8 ones, one idle cycle, then 8 zeros; load_ready=0 for all 16 SHIFT cycles; exactly 2 done pulses.
4. Back-to-back, PAR2SER_PRELOAD_EN defined: same stimulus → 16 consecutive s_valid cycles with no gap; second word accepted in cycle 1; load_ready=0 until the hold register drains at cycle 8.
5. Reset mid-word: load 8'hA5, assert rst in cycle 4 → s_valid=0 and s_data=0 from cycle 5; no done pulse; a new word loaded after reset is emitted intact.
6. End-to-end with the detector: stream 8'b1010_0000, MSB-first → detector output asserts once, after the third serial bit.

Source files
------------

// File: rtl/par2ser_shifter_if.sv
// Load handshake and serial-output bundle for par2ser_shifter.
// The master drives load_* and observes the serial side; the slave is the shifter.
interface par2ser_shifter_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             s_data;
   logic             s_valid;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_data,
      input  load_ready, s_data, s_valid, busy, done
   );

   modport slave (
      input  load_valid, load_data,
      output load_ready, s_data, s_valid, busy, done
   );
endinterface

// File: rtl/par2ser_shifter.sv
// Parallel-to-serial shifter feeding the serial pattern detector.
// Define PAR2SER_PRELOAD_EN to add a one-word holding register for gapless streaming.
module par2ser_shifter #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic              clk,
   input logic              rst,
   par2ser_shifter_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] sh_reg, sh_next;
   logic [WIDTH-1:0] sh_adv;
   logic             s_data_reg, s_valid_reg, done_reg;
   logic             load_ready;
   logic             accept;
`ifdef PAR2SER_PRELOAD_EN
   logic [WIDTH-1:0] hold_reg, hold_next;
   logic             hold_full_reg, hold_full_next;
`endif

   // Shift toward the head bit so the next payload bit is always at the head.
   assign sh_adv = MSB_FIRST ? {sh_reg[WIDTH-2:0], 1'b0} : {1'b0, sh_reg[WIDTH-1:1]};

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sh_next    = sh_reg;
`ifdef PAR2SER_PRELOAD_EN
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
      load_ready     = !rst && !hold_full_reg;
`else
      load_ready     = !rst && (state_reg == IDLE);
`endif
      accept = bus.load_valid && load_ready;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               sh_next    = bus.load_data;
               cnt_next   = CNT_LAST;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_reg != '0) begin
               sh_next  = sh_adv;
               cnt_next = cnt_reg - CW'(1);
`ifdef PAR2SER_PRELOAD_EN
               if (accept) begin
                  hold_next      = bus.load_data;
                  hold_full_next = 1'b1;
               end
`endif
            end else begin
`ifdef PAR2SER_PRELOAD_EN
               if (hold_full_reg) begin
                  sh_next        = hold_reg;
                  cnt_next       = CNT_LAST;
                  hold_full_next = 1'b0;
               end else if (accept) begin
                  sh_next  = bus.load_data;
                  cnt_next = CNT_LAST;
               end else begin
                  sh_next    = '0;
                  state_next = IDLE;
               end
`else
               sh_next    = '0;
               state_next = IDLE;
`endif
            end
         end
         default: begin
            sh_next    = '0;
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with the shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         sh_reg      <= '0;
         s_data_reg  <= 1'b0;
         s_valid_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         sh_reg      <= sh_next;
         s_valid_reg <= (state_next == SHIFT);
         s_data_reg  <= (state_next == SHIFT) &&
                        (MSB_FIRST ? sh_next[WIDTH-1] : sh_next[0]);
         done_reg    <= (state_next == SHIFT) && (cnt_next == '0);
      end
   end

`ifdef PAR2SER_PRELOAD_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
      end else begin
         hold_reg      <= hold_next;
         hold_full_reg <= hold_full_next;
      end
   end
`endif

   assign bus.load_ready = load_ready;
   assign bus.s_data     = s_data_reg;
   assign bus.s_valid    = s_valid_reg;
   assign bus.done       = done_reg;
   assign bus.busy       = (state_reg == SHIFT);
endmodule

// File: tb/tb_par2ser_shifter.sv
// Scoreboard bench for par2ser_shifter: MSB-first and LSB-first instances share one stimulus.
// Each instance has its own expected-bit queue checked by an independent negedge monitor.
module tb_par2ser_shifter;
   localparam int W = 8;
`ifdef PAR2SER_PRELOAD_EN
   localparam bit PRELOAD = 1'b1;
`else
   localparam bit PRELOAD = 1'b0;
`endif

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load_valid;
   logic [W-1:0] load_data;

   exp_t q_msb[$];
   exp_t q_lsb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic mon_en   = 1'b0;
   int   cyc      = 0;

   // Span tracking for gap checks and a behavioural "101" detector on the MSB-first stream.
   logic track = 1'b0;
   int   first_v, last_v, vcnt, dcnt;
   logic [2:0] det_hist;
   int   det_idx, det_hits, det_pos;

   always #5 clk = ~clk;

   par2ser_shifter_if #(.WIDTH(W)) ifm ();
   par2ser_shifter_if #(.WIDTH(W)) ifl ();

   assign ifm.load_valid = load_valid;
   assign ifm.load_data  = load_data;
   assign ifl.load_valid = load_valid;
   assign ifl.load_data  = load_data;

   par2ser_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(ifm));
   par2ser_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(ifl));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic exp_rdy;
      if (mon_en) begin
         exp_rdy = rst ? 1'b0 : (PRELOAD ? (q_msb.size() <= W) : (q_msb.size() == 0));
         chk("msb_load_ready", ifm.load_ready, exp_rdy);
         chk("msb_s_valid", ifm.s_valid, q_msb.size() > 0);
         chk("msb_busy", ifm.busy, q_msb.size() > 0);
         if (q_msb.size() > 0 && ifm.s_valid) begin
            e = q_msb.pop_front();
            chk("msb_s_data", ifm.s_data, e.b);
            chk("msb_done", ifm.done, e.last);
            det_hist = {det_hist[1:0], ifm.s_data};
            det_idx++;
            if (det_hist == 3'b101) begin
               det_hits++;
               det_pos = det_idx;
            end
         end else if (q_msb.size() == 0) begin
            chk("msb_idle_s_data", ifm.s_data, 1'b0);
            chk("msb_idle_done", ifm.done, 1'b0);
         end
         if (track && ifm.s_valid) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            vcnt++;
            if (ifm.done) dcnt++;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      exp_t e;
      logic exp_rdy;
      if (mon_en) begin
         exp_rdy = rst ? 1'b0 : (PRELOAD ? (q_lsb.size() <= W) : (q_lsb.size() == 0));
         chk("lsb_load_ready", ifl.load_ready, exp_rdy);
         chk("lsb_s_valid", ifl.s_valid, q_lsb.size() > 0);
         if (q_lsb.size() > 0 && ifl.s_valid) begin
            e = q_lsb.pop_front();
            chk("lsb_s_data", ifl.s_data, e.b);
            chk("lsb_done", ifl.done, e.last);
         end else if (q_lsb.size() == 0) begin
            chk("lsb_idle_s_data", ifl.s_data, 1'b0);
            chk("lsb_idle_done", ifl.done, 1'b0);
         end
      end
   end

   task automatic push_word(input logic [W-1:0] d);
      exp_t e;
      for (int i = 0; i < W; i++) begin
         e.last = (i == W - 1);
         e.b    = d[W-1-i];
         q_msb.push_back(e);
         e.b    = d[i];
         q_lsb.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds load_valid high until an edge with load_ready=1; leaves load_valid asserted.
   task automatic send(input logic [W-1:0] d);
      logic rdy;
      bit   ok;
      ok = 1'b0;
      load_valid = 1'b1;
      load_data  = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         rdy = ifm.load_ready;
         @(posedge clk);
         if (rdy) begin
            ok = 1'b1;
            push_word(d);
         end
         #1;
      end
      chk("accept_within_budget", ok, 1'b1);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      load_valid = 1'b0;
      load_data  = W'($urandom);
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         if (q_msb.size() == 0 && q_lsb.size() == 0) ok = 1'b1;
      end
      chk("drain_within_budget", ok, 1'b1);
      tick();
      tick();
   endtask

   task automatic start_track();
      track = 1'b1;
      first_v = -1;
      last_v = -1;
      vcnt = 0;
      dcnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      load_valid = 1'b0;
      load_data  = '0;
      det_hist = '0; det_idx = 0; det_hits = 0; det_pos = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Single word in both bit orders, then a lone set bit.
      send(8'hA5);
      drain();
      send(8'h01);
      drain();

      // Back-to-back with load_valid held high.
      start_track();
      send(8'hFF);
      send(8'h00);
      drain();
      track = 1'b0;
      chk("b2b_span", last_v - first_v + 1, PRELOAD ? 16 : 17);
      chk("b2b_valid_cycles", vcnt, 16);
      chk("b2b_done_pulses", dcnt, 2);

      // Second word offered only in the last-bit cycle of the first.
      start_track();
      send(8'hC3);
      load_valid = 1'b0;
      repeat (7) tick();
      send(8'h5A);
      drain();
      track = 1'b0;
      chk("late_offer_span", last_v - first_v + 1, PRELOAD ? 16 : 17);
      chk("late_offer_done_pulses", dcnt, 2);

      // Reset in cycle 4 of a word discards the rest of it.
      start_track();
      send(8'hA5);
      load_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      @(posedge clk);
      q_msb.delete();
      q_lsb.delete();
      #1;
      rst = 1'b0;
      repeat (3) tick();
      track = 1'b0;
      chk("reset_mid_valid_cycles", vcnt, 4);
      chk("reset_mid_no_done", dcnt, 0);
      send(8'h3C);
      drain();

      // Detector-style check: 1010_0000 MSB-first hits "101" once, at the third bit.
      det_hist = '0; det_idx = 0; det_hits = 0; det_pos = 0;
      send(8'b1010_0000);
      drain();
      chk("detector_hits", det_hits, 1);
      chk("detector_position", det_pos, 3);

      chk("msb_queue_empty", q_msb.size(), 0);
      chk("lsb_queue_empty", q_lsb.size(), 0);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
